morse_decoder: RTL and testbench

Parametrised successor of the single-digit Morse decoder. It decodes a debounced key line into ASCII letters (A–Z), digits (0–9) and word spaces, and classifies variable-length symbols of 1 to MAX_ELEM elements. Each decoded character goes out on a valid/ready interface, with an overflow flag and a live element indicator. The block sits between the raw key input and the character/display logic.

---
 rtl/morse_pkg.sv | 64 ++++++
 rtl/morse_decoder_if.sv | 13 +
 rtl/morse_debounce.sv | 52 +++++
 rtl/morse_decoder.sv | 139 +++++++++++++
 tb/tb_morse_decoder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared constants, live-indicator encodings, the output character record
// and the Morse code table used by the decoder.
package morse_pkg;

  localparam logic [7:0] ASCII_ERR = 8'h3F;
  localparam logic [7:0] ASCII_SPC = 8'h20;

  localparam logic [1:0] ELEM_IDLE = 2'b00;
  localparam logic [1:0] ELEM_DOT  = 2'b01;
  localparam logic [1:0] ELEM_DASH = 2'b10;
  localparam logic [1:0] ELEM_PEND = 2'b11;

  typedef struct packed {
    logic       err;
    logic [7:0] ch;
  } charRsp_t;

  // Dash = 1, first element sits in bit len-1. Returns {hit, ascii}.
  function automatic logic [8:0] decode(input logic [7:0] pattern, input logic [2:0] len);
    logic [8:0] r;
    r = '0;
    case ({len, pattern})
      {3'd1, 8'b0}:    r = {1'b1, "E"};
      {3'd1, 8'b1}:    r = {1'b1, "T"};
      {3'd2, 8'b00}:   r = {1'b1, "I"};
      {3'd2, 8'b01}:   r = {1'b1, "A"};
      {3'd2, 8'b10}:   r = {1'b1, "N"};
      {3'd2, 8'b11}:   r = {1'b1, "M"};
      {3'd3, 8'b000}:  r = {1'b1, "S"};
      {3'd3, 8'b001}:  r = {1'b1, "U"};
      {3'd3, 8'b010}:  r = {1'b1, "R"};
      {3'd3, 8'b011}:  r = {1'b1, "W"};
      {3'd3, 8'b100}:  r = {1'b1, "D"};
      {3'd3, 8'b101}:  r = {1'b1, "K"};
      {3'd3, 8'b110}:  r = {1'b1, "G"};
      {3'd3, 8'b111}:  r = {1'b1, "O"};
      {3'd4, 8'b0000}: r = {1'b1, "H"};
      {3'd4, 8'b0001}: r = {1'b1, "V"};
      {3'd4, 8'b0010}: r = {1'b1, "F"};
      {3'd4, 8'b0100}: r = {1'b1, "L"};
      {3'd4, 8'b0110}: r = {1'b1, "P"};
      {3'd4, 8'b0111}: r = {1'b1, "J"};
      {3'd4, 8'b1000}: r = {1'b1, "B"};
      {3'd4, 8'b1001}: r = {1'b1, "X"};
      {3'd4, 8'b1010}: r = {1'b1, "C"};
      {3'd4, 8'b1011}: r = {1'b1, "Y"};
      {3'd4, 8'b1100}: r = {1'b1, "Z"};
      {3'd4, 8'b1101}: r = {1'b1, "Q"};
      {3'd5, 8'b11111}: r = {1'b1, "0"};
      {3'd5, 8'b01111}: r = {1'b1, "1"};
      {3'd5, 8'b00111}: r = {1'b1, "2"};
      {3'd5, 8'b00011}: r = {1'b1, "3"};
      {3'd5, 8'b00001}: r = {1'b1, "4"};
      {3'd5, 8'b00000}: r = {1'b1, "5"};
      {3'd5, 8'b10000}: r = {1'b1, "6"};
      {3'd5, 8'b11000}: r = {1'b1, "7"};
      {3'd5, 8'b11100}: r = {1'b1, "8"};
      {3'd5, 8'b11110}: r = {1'b1, "9"};
      default:          r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Character output channel: valid/ready handshake plus status indicators.
interface morse_decoder_if;
  logic       RdyI;
  logic [7:0] CharY;
  logic       ValidY;
  logic       ErrorY;
  logic       OvfY;
  logic [1:0] ElemY;
  logic [2:0] LenY;

  modport master (input RdyI, output CharY, ValidY, ErrorY, OvfY, ElemY, LenY);
  modport slave  (output RdyI, input CharY, ValidY, ErrorY, OvfY, ElemY, LenY);
endinterface

// File: rtl/morse_debounce.sv
// Key conditioning: two-flop synchroniser followed by a stable-count filter.
// K only follows the synchronised key after DEB_CYC consecutive differing
// samples; kRise/kFall are high for the first clock of the new K level.
module morse_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic C,
  input  logic rstN,
  input  logic aM,
  output logic K,
  output logic kRise,
  output logic kFall
);
  localparam int CW = $clog2(DEB_CYC + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Bring the raw key into the clock domain.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= aM;
      s2 <= s1;
    end
  end

  // Accept a new level once it has differed from K for DEB_CYC samples.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN) begin
      cnt   <= '0;
      K     <= 1'b0;
      kRise <= 1'b0;
      kFall <= 1'b0;
    end else begin
      kRise <= 1'b0;
      kFall <= 1'b0;
      if (s2 == K) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        cnt   <= '0;
        K     <= s2;
        kRise <= s2;
        kFall <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: measures marks/spaces in units of CLK_DIV clocks,
// assembles dot/dash patterns, looks them up and hands characters (and word
// spaces) out through a single-entry valid/ready register.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CLK_DIV  = 12_500_000,
  parameter int DASH_T   = 4,
  parameter int GAP_T    = 7,
  parameter int WORD_T   = 14,
  parameter int MAX_ELEM = 6,
  parameter int DEB_CYC  = 16
) (
  input  logic            C,
  input  logic            aRn,
  input  logic            aM,
  morse_decoder_if.master bus
);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MW = $clog2(DASH_T + 1);
  localparam int GW = $clog2(WORD_T + 1);

  logic          rstN;
  logic          K, kRise, kFall, kEdge;
  logic [TW-1:0] tickCnt;
  logic          tick;
  logic [MW-1:0] markCnt;
  logic [GW-1:0] gapCnt;
  logic          gapStep, symEnd, wordEnd, emit;
  logic [7:0]    pattern;
  logic [3:0]    lenCnt;
  logic          longF, spcArm;
  logic [8:0]    lookup;
  charRsp_t      emitRsp;

  // Release reset one clock after aRn rises; assertion stays asynchronous.
  always_ff @(posedge C or negedge aRn) begin
    if (!aRn) rstN <= 1'b0;
    else      rstN <= 1'b1;
  end

  morse_debounce #(.DEB_CYC(DEB_CYC)) uDeb (
    .C(C), .rstN(rstN), .aM(aM), .K(K), .kRise(kRise), .kFall(kFall)
  );

  assign kEdge = kRise | kFall;
  // The edge clock restarts the unit so its stale count never ticks.
  assign tick  = ~kEdge & (tickCnt == TW'(CLK_DIV - 1));

  // Unit timer, phase-aligned to every K edge.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN)              tickCnt <= '0;
    else if (kEdge || tick) tickCnt <= '0;
    else                    tickCnt <= tickCnt + 1'b1;
  end

  // Mark length in units, saturating once a dash is established.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN)                                 markCnt <= '0;
    else if (kRise)                            markCnt <= '0;
    else if (tick && K && markCnt != MW'(DASH_T)) markCnt <= markCnt + 1'b1;
  end

  assign gapStep = tick & ~K & (gapCnt != GW'(WORD_T));
  assign symEnd  = gapStep & (gapCnt == GW'(GAP_T - 1)) & (lenCnt != 4'd0);
  assign wordEnd = gapStep & (gapCnt == GW'(WORD_T - 1)) & spcArm;
  assign emit    = symEnd | wordEnd;

  // Space length in units, saturating at the word threshold.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN)        gapCnt <= '0;
    else if (kRise)   gapCnt <= '0;
    else if (gapStep) gapCnt <= gapCnt + 1'b1;
  end

  // Shift in each finished element; too many elements poison the symbol.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN) begin
      pattern <= '0;
      lenCnt  <= '0;
      longF   <= 1'b0;
    end else if (symEnd) begin
      pattern <= '0;
      lenCnt  <= '0;
      longF   <= 1'b0;
    end else if (kFall) begin
      pattern <= {pattern[6:0], markCnt == MW'(DASH_T)};
      if (lenCnt < 4'(MAX_ELEM)) lenCnt <= lenCnt + 1'b1;
      else                       longF  <= 1'b1;
    end
  end

  // A word space is only owed after a character has been produced.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN)        spcArm <= 1'b0;
    else if (symEnd)  spcArm <= 1'b1;
    else if (wordEnd) spcArm <= 1'b0;
  end

  assign lookup = decode(pattern, lenCnt[2:0]);

  // Select what gets emitted this clock: decoded symbol, '?' or a space.
  always_comb begin
    emitRsp = '{err: 1'b0, ch: ASCII_SPC};
    if (symEnd) begin
      if (lookup[8] && !longF && !lenCnt[3]) emitRsp = '{err: 1'b0, ch: lookup[7:0]};
      else                                   emitRsp = '{err: 1'b1, ch: ASCII_ERR};
    end
  end

  // Single-entry output register; a character arriving while it is full
  // and not being drained is lost and flagged.
  always_ff @(posedge C or negedge rstN) begin
    if (!rstN) begin
      bus.CharY  <= 8'h00;
      bus.ErrorY <= 1'b0;
      bus.ValidY <= 1'b0;
      bus.OvfY   <= 1'b0;
    end else begin
      if (emit && (!bus.ValidY || bus.RdyI)) begin
        bus.CharY  <= emitRsp.ch;
        bus.ErrorY <= emitRsp.err;
        bus.ValidY <= 1'b1;
      end else if (bus.ValidY && bus.RdyI) begin
        bus.ValidY <= 1'b0;
      end
      if (emit && bus.ValidY && !bus.RdyI) bus.OvfY <= 1'b1;
    end
  end

  // Live indicator of the element/symbol in progress.
  always_comb begin
    bus.ElemY = ELEM_IDLE;
    if (K) bus.ElemY = (markCnt == MW'(DASH_T)) ? ELEM_DASH : ELEM_DOT;
    else if (lenCnt != 4'd0) bus.ElemY = ELEM_PEND;
  end

  assign bus.LenY = lenCnt[3] ? 3'd7 : lenCnt[2:0];
endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed scenarios plus randomized symbols and
// timing checked against a string-table reference model.
module tb_morse_decoder;
  localparam int CD = 4;

  logic C = 1'b0;
  logic aRn = 1'b0;
  logic aM = 1'b0;
  int checks = 0;
  int failures = 0;

  morse_decoder_if bus();

  morse_decoder #(
    .CLK_DIV(CD), .DASH_T(4), .GAP_T(7), .WORD_T(14), .MAX_ELEM(6), .DEB_CYC(2)
  ) dut (.C(C), .aRn(aRn), .aM(aM), .bus(bus));

  always #5 C = ~C;

  // Every completed transfer, as {ErrorY, CharY}.
  logic [8:0] obsQ[$];
  always @(negedge C) if (aRn && bus.ValidY && bus.RdyI) obsQ.push_back({bus.ErrorY, bus.CharY});

  string codes[36] = '{".-","-...","-.-.","-..",".","..-.","--.","....","..",".---",
                       "-.-",".-..","--","-.","---",".--.","--.-",".-.","...","-",
                       "..-","...-",".--","-..-","-.--","--..","-----",".----","..---",
                       "...--","....-",".....","-....","--...","---..","----."};
  string alph = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  function automatic logic [8:0] refChar(input string s);
    if (s.len() > 6) return {1'b1, 8'h3F};
    for (int i = 0; i < 36; i++) if (codes[i] == s) return {1'b0, alph[i]};
    return {1'b1, 8'h3F};
  endfunction

  task automatic clocks(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  task automatic key(input int u);
    aM = 1'b1;
    clocks(u * CD);
  endtask

  task automatic spc(input int u);
    aM = 1'b0;
    clocks(u * CD);
  endtask

  task automatic sendSym(input string s, input bit rnd);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") key(rnd ? int'($urandom_range(6, 5)) : 5);
      else             key(rnd ? int'($urandom_range(2, 1)) : 1);
      if (i < s.len() - 1) spc(rnd ? int'($urandom_range(2, 1)) : 1);
    end
  endtask

  task automatic test_reset;
    aRn = 1'b0;
    clocks(3);
    checks += 6;
    if (bus.CharY !== 8'h00)  begin failures++; $display("FAIL rst_char: got %h want 00", bus.CharY); end
    if (bus.ValidY !== 1'b0)  begin failures++; $display("FAIL rst_valid: got %b want 0", bus.ValidY); end
    if (bus.ErrorY !== 1'b0)  begin failures++; $display("FAIL rst_err: got %b want 0", bus.ErrorY); end
    if (bus.OvfY !== 1'b0)    begin failures++; $display("FAIL rst_ovf: got %b want 0", bus.OvfY); end
    if (bus.ElemY !== 2'b00)  begin failures++; $display("FAIL rst_elem: got %b want 00", bus.ElemY); end
    if (bus.LenY !== 3'd0)    begin failures++; $display("FAIL rst_len: got %0d want 0", bus.LenY); end
    aRn = 1'b1;
    clocks(4);
  endtask

  task automatic test_letter_a;
    logic [8:0] exp[$];
    exp = '{{1'b0, 8'h41}, {1'b0, 8'h20}};
    obsQ.delete();
    aM = 1'b1;
    clocks(3);
    checks++;
    if (bus.ElemY !== 2'b00) begin failures++; $display("FAIL a_deb_early: got %b want 00", bus.ElemY); end
    clocks(1);
    checks++;
    if (bus.ElemY !== 2'b01) begin failures++; $display("FAIL a_deb_dot: got %b want 01", bus.ElemY); end
    clocks(2 * CD - 4);
    spc(2);
    checks += 2;
    if (bus.LenY !== 3'd1)   begin failures++; $display("FAIL a_len1: got %0d want 1", bus.LenY); end
    if (bus.ElemY !== 2'b11) begin failures++; $display("FAIL a_pend: got %b want 11", bus.ElemY); end
    key(5);
    aM = 1'b0;
    clocks(2);
    checks++;
    if (bus.ElemY !== 2'b10) begin failures++; $display("FAIL a_dash: got %b want 10", bus.ElemY); end
    clocks(8 * CD - 2);
    checks += 2;
    if (bus.LenY !== 3'd2)    begin failures++; $display("FAIL a_len2: got %0d want 2", bus.LenY); end
    if (bus.ValidY !== 1'b0)  begin failures++; $display("FAIL a_valid_early: got %b want 0", bus.ValidY); end
    clocks(1);
    checks += 3;
    if (bus.ValidY !== 1'b1)  begin failures++; $display("FAIL a_valid: got %b want 1", bus.ValidY); end
    if (bus.CharY !== 8'h41)  begin failures++; $display("FAIL a_char: got %h want 41", bus.CharY); end
    if (bus.LenY !== 3'd0)    begin failures++; $display("FAIL a_len_clr: got %0d want 0", bus.LenY); end
    spc(20);
    checks++;
    if (obsQ.size() != exp.size()) begin failures++; $display("FAIL a_count: got %0d want %0d", obsQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== exp[i]) begin failures++; $display("FAIL a_seq%0d: got %h want %h", i, obsQ[i], exp[i]); end
    end
  endtask

  task automatic test_digits;
    logic [8:0] exp[$];
    exp = '{{1'b0, 8'h30}, {1'b0, 8'h35}, {1'b0, 8'h20}};
    obsQ.delete();
    sendSym("-----", 1'b0);
    spc(8);
    sendSym(".....", 1'b0);
    spc(20);
    checks++;
    if (obsQ.size() != exp.size()) begin failures++; $display("FAIL dig_count: got %0d want %0d", obsQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== exp[i]) begin failures++; $display("FAIL dig_seq%0d: got %h want %h", i, obsQ[i], exp[i]); end
    end
  endtask

  task automatic test_long;
    logic [8:0] exp[$];
    exp = '{{1'b1, 8'h3F}, {1'b0, 8'h20}};
    obsQ.delete();
    sendSym(".......", 1'b0);
    spc(2);
    checks++;
    if (bus.LenY !== 3'd6) begin failures++; $display("FAIL long_len: got %0d want 6", bus.LenY); end
    spc(26);
    checks++;
    if (obsQ.size() != exp.size()) begin failures++; $display("FAIL long_count: got %0d want %0d", obsQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== exp[i]) begin failures++; $display("FAIL long_seq%0d: got %h want %h", i, obsQ[i], exp[i]); end
    end
  endtask

  task automatic test_space_once;
    logic [8:0] exp[$];
    exp = '{{1'b0, 8'h45}, {1'b0, 8'h20}};
    obsQ.delete();
    sendSym(".", 1'b0);
    spc(20);
    spc(20);
    checks++;
    if (obsQ.size() != exp.size()) begin failures++; $display("FAIL spc_count: got %0d want %0d", obsQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== exp[i]) begin failures++; $display("FAIL spc_seq%0d: got %h want %h", i, obsQ[i], exp[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [8:0] exp[$];
    exp = '{{1'b0, 8'h45}, {1'b0, 8'h20}};
    obsQ.delete();
    bus.RdyI = 1'b0;
    sendSym(".", 1'b0);
    spc(8);
    sendSym("-", 1'b0);
    spc(9);
    checks += 4;
    if (bus.ValidY !== 1'b1) begin failures++; $display("FAIL ovf_valid: got %b want 1", bus.ValidY); end
    if (bus.CharY !== 8'h45) begin failures++; $display("FAIL ovf_hold: got %h want 45", bus.CharY); end
    if (bus.ErrorY !== 1'b0) begin failures++; $display("FAIL ovf_err: got %b want 0", bus.ErrorY); end
    if (bus.OvfY !== 1'b1)   begin failures++; $display("FAIL ovf_flag: got %b want 1", bus.OvfY); end
    bus.RdyI = 1'b1;
    clocks(1);
    checks++;
    if (bus.ValidY !== 1'b0) begin failures++; $display("FAIL ovf_release: got %b want 0", bus.ValidY); end
    spc(20);
    checks += 2;
    if (bus.OvfY !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", bus.OvfY); end
    if (obsQ.size() != exp.size()) begin failures++; $display("FAIL ovf_count: got %0d want %0d", obsQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== exp[i]) begin failures++; $display("FAIL ovf_seq%0d: got %h want %h", i, obsQ[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] exp[$];
    exp = '{{1'b0, 8'h54}, {1'b0, 8'h20}};
    aM = 1'b1;
    clocks(3 * CD);
    aRn = 1'b0;
    aM = 1'b0;
    clocks(2);
    checks += 5;
    if (bus.CharY !== 8'h00) begin failures++; $display("FAIL rm_char: got %h want 00", bus.CharY); end
    if (bus.ValidY !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b want 0", bus.ValidY); end
    if (bus.OvfY !== 1'b0)   begin failures++; $display("FAIL rm_ovf: got %b want 0", bus.OvfY); end
    if (bus.ElemY !== 2'b00) begin failures++; $display("FAIL rm_elem: got %b want 00", bus.ElemY); end
    if (bus.LenY !== 3'd0)   begin failures++; $display("FAIL rm_len: got %0d want 0", bus.LenY); end
    aRn = 1'b1;
    clocks(8);
    obsQ.delete();
    sendSym("-", 1'b0);
    spc(28);
    checks++;
    if (obsQ.size() != exp.size()) begin failures++; $display("FAIL rm_count: got %0d want %0d", obsQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== exp[i]) begin failures++; $display("FAIL rm_seq%0d: got %h want %h", i, obsQ[i], exp[i]); end
    end
  endtask

  task automatic test_random;
    logic [8:0] exp[$];
    string s;
    obsQ.delete();
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(9, 0) < 7) begin
        s = codes[$urandom_range(35, 0)];
      end else begin
        s = "";
        for (int j = $urandom_range(7, 1); j > 0; j--) s = {s, ($urandom_range(1, 0) != 0) ? "-" : "."};
      end
      sendSym(s, 1'b1);
      exp.push_back(refChar(s));
      if (n == 11 || $urandom_range(2, 0) == 0) begin
        spc($urandom_range(20, 16));
        exp.push_back({1'b0, 8'h20});
      end else begin
        spc($urandom_range(10, 8));
      end
    end
    checks++;
    if (obsQ.size() != exp.size()) begin failures++; $display("FAIL rnd_count: got %0d want %0d", obsQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== exp[i]) begin failures++; $display("FAIL rnd_seq%0d: got %h want %h", i, obsQ[i], exp[i]); end
    end
  endtask

  initial begin
    bus.RdyI = 1'b1;
    test_reset();
    test_letter_a();
    test_digits();
    test_long();
    test_space_once();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
